// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch initiator. Holds the program counter, issues
//             four consecutive byte reads per instruction to a byte-addressed
//             instruction memory, assembles them little-endian into a 32-bit
//             word and offers it to decode over a valid/ready handshake.
//             Redirects from branch/jump resolution are accepted in any state.
//  Ports    : clock, reset_n        - clock / async active-low reset
//             mem_address           - byte address to instruction memory
//             mem_read_write        - always 0 (read)
//             mem_data_out          - byte returned one cycle after address
//             redirect_valid/_pc    - load new PC (highest priority)
//             inst_valid/_ready     - handshake to decode
//             inst, inst_pc         - assembled word and its PC
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int unsigned          ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0100_0000
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read_write,
   input  logic [7:0]        mem_data_out,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam logic [1:0] ST_ISSUE = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [23:0]       buf_q, buf_d;      // byte lanes 0..2; lane 3 goes straight to inst
   logic              valid_q, valid_d;
   logic [31:0]       inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

   // Word-aligned redirect target; masking keeps every input bit in use.
   logic [ADDR_W-1:0] redirect_aligned;
   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

   assign mem_read_write = 1'b0;

   always_comb begin
      if (state_q == ST_ISSUE) begin
         mem_address = pc_q + ADDR_W'(cnt_q);
      end else begin
         mem_address = pc_q + ADDR_W'(3);
      end
   end

   always_comb begin
      pc_d      = pc_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      valid_d   = valid_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;

      case (state_q)
         ST_ISSUE: begin
            // The byte arriving now belongs to the address issued last cycle.
            case (cnt_q)
               2'd1:    buf_d[7:0]   = mem_data_out;
               2'd2:    buf_d[15:8]  = mem_data_out;
               2'd3:    buf_d[23:16] = mem_data_out;
               default: ;
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            inst_d    = {mem_data_out, buf_q};
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            if (valid_q && inst_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + ADDR_W'(4);
               cnt_d   = 2'd0;
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_ISSUE;
            cnt_d   = 2'd0;
         end
      endcase

      // Redirect overrides everything: partial bytes and a word completing
      // in DRAIN are dropped; a word in HOLD counts as consumed.
      if (redirect_valid) begin
         pc_d      = redirect_aligned;
         cnt_d     = 2'd0;
         state_d   = ST_ISSUE;
         valid_d   = 1'b0;
         buf_d     = '0;
         inst_d    = inst_q;
         inst_pc_d = inst_pc_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q      <= RESET_PC;
         state_q   <= ST_ISSUE;
         cnt_q     <= 2'd0;
         buf_q     <= '0;
         valid_q   <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         buf_q     <= buf_d;
         valid_q   <= valid_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with a byte memory
//             model and an expected-instruction queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0100_0000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mem_address;
   logic        mem_read_write;
   logic [7:0]  mem_data_out = 8'h00;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .mem_address    (mem_address),
      .mem_read_write (mem_read_write),
      .mem_data_out   (mem_data_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0100_0000: return 8'h13;
         32'h0100_0001: return 8'h05;
         32'h0100_0002: return 8'hA0;
         32'h0100_0003: return 8'h00;
         default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
      endcase
   endfunction

   // Memory returns the byte one cycle after the address is presented.
   always @(posedge clock) mem_data_out <= mem_byte(mem_address);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
      sb.push_back(e);
   endtask

   task automatic wait_inst(input string tag);
      int n = 0;
      exp_t e;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_inst"}, inst, e.word);
         chk({tag, "_pc"}, inst_pc, e.pc);
      end
   endtask

   initial begin
      logic [31:0] hold_inst;
      logic [31:0] hold_pc;

      // Reset state
      tick();
      tick();
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_addr", mem_address, RST_PC);
      chk("rst_rw", {31'd0, mem_read_write}, 32'd0);

      // 1: first fetch, latency and address stepping
      inst_ready = 1'b1;
      reset_n = 1'b1;
      push_exp(RST_PC);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_addr%0d", i), mem_address, RST_PC + 32'(i));
         tick();
      end
      chk("t1_drain_addr", mem_address, RST_PC + 32'd3);
      chk("t1_c4_valid", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("t1_c5_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_word", inst, 32'h00A0_0513);
      wait_inst("t1");
      tick();
      chk("t1_next_addr", mem_address, RST_PC + 32'd4);
      chk("t1_next_valid", {31'd0, inst_valid}, 32'd0);

      // 2: back-pressure for 10 cycles
      inst_ready = 1'b0;
      push_exp(RST_PC + 32'd4);
      wait_inst("t2");
      hold_inst = inst;
      hold_pc   = inst_pc;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
         chk("t2_hold_inst", inst, hold_inst);
         chk("t2_hold_pc", inst_pc, hold_pc);
         chk("t2_hold_addr", mem_address, RST_PC + 32'd7);
      end
      inst_ready = 1'b1;
      tick();
      chk("t2_next_addr", mem_address, RST_PC + 32'd8);
      chk("t2_next_valid", {31'd0, inst_valid}, 32'd0);

      // 3: redirect while cnt==2
      tick();
      tick();
      chk("t3_cnt2_addr", mem_address, RST_PC + 32'd10);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0100_0042;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      chk("t3_redir_addr", mem_address, 32'h0100_0040);
      chk("t3_redir_valid", {31'd0, inst_valid}, 32'd0);
      push_exp(32'h0100_0040);
      wait_inst("t3");

      // 4: redirect together with handshake in HOLD
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      inst_ready     = 1'b1;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      chk("t4_valid", {31'd0, inst_valid}, 32'd0);
      chk("t4_addr", mem_address, 32'h0000_0200);
      push_exp(32'h0000_0200);
      wait_inst("t4");

      // 5: wrap-around at top of address space (unaligned target gets aligned)
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      chk("t5_addr_top", mem_address, 32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC);
      wait_inst("t5");
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("t5_valid", {31'd0, inst_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t5_wrap_addr%0d", i), mem_address, 32'(i));
         tick();
      end
      chk("t5_drain_addr", mem_address, 32'd3);

      // 6: asynchronous reset between edges while in DRAIN
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6_valid", {31'd0, inst_valid}, 32'd0);
      chk("t6_addr", mem_address, RST_PC);
      chk("t6_inst", inst, 32'd0);
      tick();
      chk("t6_still_valid", {31'd0, inst_valid}, 32'd0);
      reset_n    = 1'b1;
      inst_ready = 1'b1;
      chk("t6_resume_addr", mem_address, RST_PC);
      push_exp(RST_PC);
      wait_inst("t6");
      chk("t6_sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
